mul_share_sched: RTL
====================

// Module: mul_share_sched
// PURPOSE
// Round-robin scheduler sharing one packed dual-int8 multiplier between NUM_REQ requesters.
// Each request carries two multiplicands (a, b) and one shared multiplicand (e); one request is
// issued per clk cycle to the multiplier. A tag pipeline tracks in-flight issues and a credit-
// guarded response FIFO absorbs the fixed-latency products so the consumer may back-pressure.
// Sits between the systolic-array operand feeders and the shared multiplier.
// PARAMETERS
// NUM_REQ     4   number of requesters (>=2)
// IN_BITS     8   signed operand width of a, b, e
// PROD_BITS   32  signed product width, sign-extended by the multiplier
// MUL_LAT     4   multiplier latency in clk cycles, issue to product valid (>=1)
// FIFO_DEPTH  8   response FIFO entries = total credits (>=1, power of 2)
// ID_BITS     localparam = $clog2(NUM_REQ)
// PORTS
// clk        in   1                  single clock
// rst        in   1                  asynchronous, active-low reset
// req_valid  in   NUM_REQ            per-requester request valid
// req_ready  out  NUM_REQ            per-requester accept (one-hot or zero)
// req_a      in   NUM_REQ*IN_BITS    flattened operand a, requester i at [i*IN_BITS +: IN_BITS]
// req_b      in   NUM_REQ*IN_BITS    flattened operand b
// req_e      in   NUM_REQ*IN_BITS    flattened shared operand e
// mul_issue  out  1                  registered issue strobe to multiplier
// mul_a      out  IN_BITS            registered operand a to multiplier
// mul_b      out  IN_BITS            registered operand b to multiplier
// mul_e      out  IN_BITS            registered operand e to multiplier
// mul_pa     in   PROD_BITS          product a*e from multiplier
// mul_pb     in   PROD_BITS          product b*e from multiplier
// rsp_valid  out  1                  response FIFO head valid
// rsp_ready  in   1                  consumer pop
// rsp_id     out  ID_BITS            requester index of head response
// rsp_pa     out  PROD_BITS          head a*e
// rsp_pb     out  PROD_BITS          head b*e
// BEHAVIOUR
// - Reset (rst=0, async): mul_issue/mul_a/mul_b/mul_e=0, rsp_valid=0, rsp_id/pa/pb=0, tag pipe
//   cleared, FIFO empty, credits=FIFO_DEPTH, rr pointer=NUM_REQ-1 (requester 0 first priority).
// - req_ready is combinational: one-hot grant when credits>0, else all zero. Grant = first
//   req_valid searching from (ptr+1) mod NUM_REQ upward with wrap. Handshake = valid&ready;
//   requesters hold valid and operands until accepted. ptr <= granted index on handshake only.
// - Handshake in cycle t: mul_issue=1 and operands of granter visible in cycle t+1; otherwise
//   mul_issue=0 and mul_a/b/e hold last values. Products sampled in cycle t+1+MUL_LAT.
// - Tag pipe: MUL_LAT+1 stages of {valid,id}, shifted every cycle, entered on handshake. When
//   stage-out valid, {id, mul_pa, mul_pb} written to FIFO at end of that cycle.
// - FIFO: first-word-fall-through; rsp_* reflect head; rsp_valid=~empty. Earliest rsp_valid is
//   cycle t+MUL_LAT+2. Pop on rsp_valid&rsp_ready. Simultaneous write and pop allowed in any state.
// - Credits: -1 on handshake, +1 on pop, unchanged on both same cycle. credits=0 -> no grant.
//   Credits guarantee FIFO never overflows; write-while-full is an assertion failure.
// - Responses leave in issue order; no reordering, no drop. Widths: products taken as given.
// - Reset mid-operation: in-flight tags and FIFO contents discarded; products arriving after
//   reset release are ignored; no rsp_valid until a new issue completes.
// TESTING
// T1 req0 a=3,b=-5,e=7 -> mul_issue next cycle; rsp id=0 pa=32'd21 pb=32'hFFFFFFDD at t+6.
// T2 all 4 req_valid held, rsp_ready=1 -> grants 0,1,2,3,0,1.. one per cycle, rsp ids in order.
// T3 rsp_ready=0, all valid -> exactly 8 handshakes then req_ready=0; one pop -> one more grant.
// T4 a=-128,b=127,e=-128 -> pa=32'd16384, pb=32'hFFFFC080 (-16256).
// T5 pop and handshake same cycle at credits=1 -> credits stays 1, FIFO count consistent.
// T6 rst low with 3 in flight and 2 in FIFO -> outputs zero immediately; no rsp after release; req0 granted first.

Source files
------------

// File: rtl/mul_share_sched.sv
// Generic first-word-fall-through FIFO used for the product response queue.
// Latency: a write is visible at the head on the cycle after it is written.
// Backpressure: none internally; the caller must never write while full.
module mul_share_sched_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          pop;
    logic          full;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop    = rd_vld && rd_rdy;
    assign rd_vld = (count != '0);
    assign full   = (count == CW'(DEPTH));
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_vld) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) wr_ptr <= nxt(wr_ptr);
            if (pop)    rd_ptr <= nxt(rd_ptr);
            case ({wr_vld, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(wr_vld && full));

endmodule

// Round-robin scheduler sharing one packed dual-int8 multiplier among NUM_REQ requesters.
// Latency: issue one cycle after handshake; response head valid MUL_LAT+2 cycles after handshake.
// Backpressure: credits cover FIFO space including in-flight products; zero credits blocks grants.
module mul_share_sched #(
    parameter int  NUM_REQ    = 4,
    parameter int  IN_BITS    = 8,
    parameter int  PROD_BITS  = 32,
    parameter int  MUL_LAT    = 4,
    parameter int  FIFO_DEPTH = 8,
    localparam int ID_BITS    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*IN_BITS-1:0] req_a,
    input  logic [NUM_REQ*IN_BITS-1:0] req_b,
    input  logic [NUM_REQ*IN_BITS-1:0] req_e,
    output logic                       mul_issue,
    output logic [IN_BITS-1:0]         mul_a,
    output logic [IN_BITS-1:0]         mul_b,
    output logic [IN_BITS-1:0]         mul_e,
    input  logic [PROD_BITS-1:0]       mul_pa,
    input  logic [PROD_BITS-1:0]       mul_pb,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_BITS-1:0]         rsp_id,
    output logic [PROD_BITS-1:0]       rsp_pa,
    output logic [PROD_BITS-1:0]       rsp_pb
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ID_BITS-1:0]   id;
        logic [PROD_BITS-1:0] pa;
        logic [PROD_BITS-1:0] pb;
    } rsp_t;

    logic [ID_BITS-1:0] ptr;
    logic [CW-1:0]      credits;
    logic [ID_BITS-1:0] gnt_id;
    logic [ID_BITS-1:0] cand;
    logic               gnt_found;
    logic               hs;
    logic               pop;
    logic [MUL_LAT:0]   tag_vld;
    logic [ID_BITS-1:0] tag_id [MUL_LAT+1];
    rsp_t               wr_dat;
    rsp_t               head;
    logic               head_vld;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        req_ready = '0;
        gnt_id    = '0;
        gnt_found = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_BITS'((int'(ptr) + i) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
        if (gnt_found && credits != '0) req_ready[gnt_id] = 1'b1;
    end

    assign hs  = |(req_valid & req_ready);
    assign pop = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= ID_BITS'(NUM_REQ - 1);
            credits   <= CW'(FIFO_DEPTH);
            mul_issue <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_e     <= '0;
        end else begin
            mul_issue <= hs;
            if (hs) begin
                ptr   <= gnt_id;
                mul_a <= req_a[gnt_id*IN_BITS +: IN_BITS];
                mul_b <= req_b[gnt_id*IN_BITS +: IN_BITS];
                mul_e <= req_e[gnt_id*IN_BITS +: IN_BITS];
            end
            case ({hs, pop})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    // Tag stage MUL_LAT lines up with the cycle the multiplier presents that issue's products.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld <= '0;
            for (int k = 0; k <= MUL_LAT; k++) tag_id[k] <= '0;
        end else begin
            tag_vld   <= {tag_vld[MUL_LAT-1:0], hs};
            tag_id[0] <= gnt_id;
            for (int k = 1; k <= MUL_LAT; k++) tag_id[k] <= tag_id[k-1];
        end
    end

    assign wr_dat = '{id: tag_id[MUL_LAT], pa: mul_pa, pb: mul_pb};

    mul_share_sched_fifo #(
        .W     ($bits(rsp_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (tag_vld[MUL_LAT]),
        .wr_dat (wr_dat),
        .rd_vld (head_vld),
        .rd_rdy (rsp_ready),
        .rd_dat (head)
    );

    // Head fields are forced to zero while empty so stale storage never leaks out.
    assign rsp_valid = head_vld;
    assign rsp_id    = head_vld ? head.id : '0;
    assign rsp_pa    = head_vld ? head.pa : '0;
    assign rsp_pb    = head_vld ? head.pb : '0;

endmodule
